// File: rtl/inversion_sequencer.sv
// inversion_sequencer
//   Job-level controller for the Cholesky-based 8x8 complex matrix inversion
//   chain. Accepts one job at a time, fires a one-cycle start to each stage in
//   turn (Cholesky -> lower-triangular inverse -> L^-H*L^-1 product), waits for
//   each stage's done pulse, and returns a tagged response. A per-stage
//   watchdog converts a hung stage into an error response.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   abort                 synchronous abort to IDLE, no response issued
//   job_valid/job_ready   job request handshake; job_tag captured on accept
//   chol_start/chol_done  Cholesky stage start / done pulses
//   linv_start/linv_done  lower-inverse stage start / done pulses
//   prod_start/prod_done  product stage start / done pulses
//   res_valid/res_ready   response handshake; res_tag, res_err, res_stage
//   busy                  high in every state except IDLE
//   job_count             error-free responses handed off (wraps)
module inversion_sequencer #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [TAG_W-1:0] job_tag,
    output logic             chol_start,
    input  logic             chol_done,
    output logic             linv_start,
    input  logic             linv_done,
    output logic             prod_start,
    input  logic             prod_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic [1:0]       res_stage,
    output logic             busy,
    output logic [15:0]      job_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHOL_GO,
        S_CHOL_WAIT,
        S_LINV_GO,
        S_LINV_WAIT,
        S_PROD_GO,
        S_PROD_WAIT,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wcnt;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [1:0]       stage_q;
    logic [15:0]      count_q;
    logic             timeout_hit;
    logic             fail;
    logic [1:0]       fail_stage;

    assign timeout_hit = (wcnt == WCNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; done is checked before the watchdog so a done arriving
    // on the last permitted cycle still counts as success.
    always_comb begin
        state_next = state;
        fail       = 1'b0;
        fail_stage = 2'd0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:      if (job_valid) state_next = S_CHOL_GO;
                S_CHOL_GO:   state_next = S_CHOL_WAIT;
                S_CHOL_WAIT: begin
                    if (chol_done) begin
                        state_next = S_LINV_GO;
                    end else if (timeout_hit) begin
                        state_next = S_RESP;
                        fail       = 1'b1;
                        fail_stage = 2'd0;
                    end
                end
                S_LINV_GO:   state_next = S_LINV_WAIT;
                S_LINV_WAIT: begin
                    if (linv_done) begin
                        state_next = S_PROD_GO;
                    end else if (timeout_hit) begin
                        state_next = S_RESP;
                        fail       = 1'b1;
                        fail_stage = 2'd1;
                    end
                end
                S_PROD_GO:   state_next = S_PROD_WAIT;
                S_PROD_WAIT: begin
                    if (prod_done) begin
                        state_next = S_RESP;
                    end else if (timeout_hit) begin
                        state_next = S_RESP;
                        fail       = 1'b1;
                        fail_stage = 2'd2;
                    end
                end
                S_RESP:      if (res_ready) state_next = S_IDLE;
                default:     state_next = S_IDLE;
            endcase
        end
    end

    // Outputs decode only the state register, never the inputs.
    always_comb begin
        job_ready  = (state == S_IDLE);
        busy       = (state != S_IDLE);
        chol_start = (state == S_CHOL_GO);
        linv_start = (state == S_LINV_GO);
        prod_start = (state == S_PROD_GO);
        res_valid  = (state == S_RESP);
    end

    assign res_tag   = tag_q;
    assign res_err   = err_q;
    assign res_stage = stage_q;
    assign job_count = count_q;

    // Job tag, error record, watchdog and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt    <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            stage_q <= 2'd0;
            count_q <= '0;
        end else begin
            if (state == S_IDLE && state_next == S_CHOL_GO) begin
                tag_q   <= job_tag;
                err_q   <= 1'b0;
                stage_q <= 2'd0;
            end
            if (fail) begin
                err_q   <= 1'b1;
                stage_q <= fail_stage;
            end
            if (state inside {S_CHOL_GO, S_LINV_GO, S_PROD_GO}) begin
                wcnt <= '0;
            end else if (state inside {S_CHOL_WAIT, S_LINV_WAIT, S_PROD_WAIT}) begin
                wcnt <= wcnt + CNT_W'(1);
            end
            if (state == S_RESP && res_ready && !abort && !err_q) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule
